// File: rtl/delay_pipe.sv
// Elastic register pipeline of DEPTH stages carrying a round index and payload.
// Stalled stages hold their contents, and empty stages (bubbles) are filled by the stage behind them.
module delay_pipe #(
  parameter int unsigned WIDTH = 512,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_en,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_round,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_round,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  generate
    if (DEPTH < 1 || DEPTH > 16) begin : g_depth_check
      $error("delay_pipe: DEPTH must be in 1..16");
    end
  endgenerate

  logic [DEPTH-1:0] r_v;
  logic [7:0]       r_round [DEPTH];
  logic [WIDTH-1:0] r_data  [DEPTH];
  logic [CW-1:0]    r_count;

  logic [DEPTH-1:0] w_adv;
  logic             w_acc;
  logic             w_emit;

  // A stage may advance when the output drains or when any stage ahead of it is
  // empty. The check is written as a scan from the output side so that no
  // element of w_adv depends on another element of the same vector.
  always_comb begin
    logic w_bubble;
    w_bubble = 1'b0;
    w_adv    = '0;
    for (int unsigned j = DEPTH; j > 0; j--) begin
      w_adv[j-1] = out_ready | w_bubble;
      w_bubble   = w_bubble | ~r_v[j-1];
    end
  end

  assign in_ready = ~flush & (~r_v[0] | w_adv[0]);
  assign w_acc    = in_valid & in_ready;
  assign w_emit   = r_v[DEPTH-1] & out_ready;

  always_ff @(posedge clk or negedge reset_en) begin
    if (!reset_en) begin
      r_v     <= '0;
      r_count <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        r_round[k] <= '0;
        r_data[k]  <= '0;
      end
    end else begin
      if (w_acc) begin
        r_v[0]     <= 1'b1;
        r_round[0] <= in_round;
        r_data[0]  <= in_data;
      end else if (w_adv[0]) begin
        r_v[0] <= 1'b0;
      end

      for (int unsigned k = 1; k < DEPTH; k++) begin
        if (w_adv[k-1] && r_v[k-1]) begin
          r_v[k]     <= 1'b1;
          r_round[k] <= r_round[k-1];
          r_data[k]  <= r_data[k-1];
        end else if (w_adv[k]) begin
          r_v[k] <= 1'b0;
        end
      end

      // Flush wins over any movement; payload registers may keep stale data.
      if (flush) begin
        r_v     <= '0;
        r_count <= '0;
      end else if (w_acc && !w_emit) begin
        r_count <= r_count + CW'(1);
      end else if (!w_acc && w_emit) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  assign out_valid = r_v[DEPTH-1];
  assign out_round = r_round[DEPTH-1];
  assign out_data  = r_data[DEPTH-1];
  assign count     = r_count;

endmodule

// File: tb/tb_delay_pipe.sv
// Directed bench for delay_pipe: a DEPTH=4 instance for the main scenarios and a
// DEPTH=1 instance driven by a randomised stall pattern against a queue model.
module tb_delay_pipe;

  localparam int unsigned W = 512;

  logic clk;
  logic reset_en;

  logic         flush, in_valid, in_ready, out_valid, out_ready;
  logic [7:0]   in_round, out_round;
  logic [W-1:0] in_data, out_data;
  logic [2:0]   count;

  logic         flush1, in_valid1, in_ready1, out_valid1, out_ready1;
  logic [7:0]   in_round1, out_round1;
  logic [W-1:0] in_data1, out_data1;
  logic [0:0]   count1;

  int n_checks = 0;
  int n_errors = 0;

  delay_pipe #(.WIDTH(W), .DEPTH(4)) dut (
    .clk(clk), .reset_en(reset_en), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_round(in_round), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_round(out_round), .out_data(out_data),
    .count(count)
  );

  delay_pipe #(.WIDTH(W), .DEPTH(1)) dut1 (
    .clk(clk), .reset_en(reset_en), .flush(flush1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_round(in_round1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_round(out_round1), .out_data(out_data1),
    .count(count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish within 200000 time units");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mkdata(input logic [7:0] r);
    return {(W/8){r ^ 8'hA5}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] r, input logic ordy);
    in_valid  = v;
    in_round  = r;
    in_data   = mkdata(r);
    out_ready = ordy;
  endtask

  logic [7:0] q[$];
  int sent, recv, exp_cnt, c;
  logic emit, acc;

  initial begin
    reset_en = 1'b0;
    flush = 1'b0; flush1 = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    in_valid1 = 1'b0; in_round1 = '0; in_data1 = '0; out_ready1 = 1'b0;
    #3;
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_count",     W'(count), W'(0));
    check("rst_out_round", W'(out_round), W'(0));
    check("rst_out_data",  out_data, '0);
    check("rst1_out_valid", W'(out_valid1), W'(0));
    @(negedge clk);
    reset_en = 1'b1;
    #1;
    check("post_rst_in_ready", W'(in_ready), W'(1));

    // Back-to-back stream of rounds 0..9 with no stalls.
    for (c = 0; c < 15; c++) begin
      drive(c < 10, 8'(c), 1'b1);
      #1;
      exp_cnt = ((c < 10) ? c : 10) - ((c > 4) ? ((c - 4 < 10) ? c - 4 : 10) : 0);
      check("stream_in_ready", W'(in_ready), W'(1));
      check("stream_count", W'(count), W'(exp_cnt));
      check("stream_out_valid", W'(out_valid), W'(c >= 4 && c <= 13));
      if (c >= 4 && c <= 13) begin
        check("stream_out_round", W'(out_round), W'(c - 4));
        check("stream_out_data", out_data, mkdata(8'(c - 4)));
      end
      step();
    end

    // Fill four words, then stall the output for six cycles.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(20 + i), 1'b0);
      #1;
      check("fill_in_ready", W'(in_ready), W'(1));
      step();
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 8'd24, 1'b0);
      #1;
      check("stall_in_ready", W'(in_ready), W'(0));
      check("stall_count", W'(count), W'(4));
      check("stall_out_round", W'(out_round), W'(20));
      check("stall_out_valid", W'(out_valid), W'(1));
      step();
    end
    drive(1'b1, 8'd24, 1'b1);
    #1;
    check("full_pass_in_ready", W'(in_ready), W'(1));
    step();
    drive(1'b0, 8'd0, 1'b1);
    #1;
    check("full_pass_count", W'(count), W'(4));
    for (int i = 0; i < 4; i++) begin
      check("drain_out_round", W'(out_round), W'(21 + i));
      check("drain_count", W'(count), W'(4 - i));
      step();
    end
    check("drain_empty", W'(out_valid), W'(0));

    // One word travels to the last stage on its own, then three more pack in behind it.
    drive(1'b1, 8'd30, 1'b0);
    #1;
    check("bub_in_ready", W'(in_ready), W'(1));
    step();
    for (int i = 1; i < 4; i++) begin
      drive(1'b0, 8'd0, 1'b0);
      #1;
      check("bub_not_yet", W'(out_valid), W'(0));
      step();
    end
    check("bub_arrive_valid", W'(out_valid), W'(1));
    check("bub_arrive_round", W'(out_round), W'(30));
    check("bub_arrive_count", W'(count), W'(1));
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(31 + i), 1'b0);
      #1;
      check("bub_fill_in_ready", W'(in_ready), W'(1));
      step();
    end
    drive(1'b0, 8'd0, 1'b0);
    #1;
    check("bub_full_count", W'(count), W'(4));
    check("bub_full_in_ready", W'(in_ready), W'(0));
    check("bub_full_round", W'(out_round), W'(30));
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bub_drain_round", W'(out_round), W'(30 + i));
      step();
    end

    // Flush with three words in flight and a concurrent input.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(40 + i), 1'b0);
      step();
    end
    drive(1'b1, 8'd43, 1'b0);
    flush = 1'b1;
    #1;
    check("flush_in_ready", W'(in_ready), W'(0));
    step();
    flush = 1'b0;
    drive(1'b0, 8'd0, 1'b1);
    #1;
    check("flush_count", W'(count), W'(0));
    check("flush_out_valid", W'(out_valid), W'(0));
    for (int i = 0; i < 6; i++) begin
      step();
      check("flush_no_output", W'(out_valid), W'(0));
    end

    // Asynchronous reset with the pipe full.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(50 + i), 1'b0);
      step();
    end
    drive(1'b0, 8'd0, 1'b0);
    #1;
    check("prerst_count", W'(count), W'(4));
    #1;
    reset_en = 1'b0;
    #1;
    check("arst_out_valid", W'(out_valid), W'(0));
    check("arst_count", W'(count), W'(0));
    check("arst_out_round", W'(out_round), W'(0));
    check("arst_out_data", out_data, '0);
    @(negedge clk);
    reset_en = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("after_rst_count", W'(count), W'(0));
      check("after_rst_out_valid", W'(out_valid), W'(0));
    end

    // DEPTH=1 instance under a random stall pattern, then a drain.
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 64; cyc++) begin
      in_valid1  = (cyc < 60) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_round1  = 8'(sent);
      in_data1   = mkdata(8'(sent));
      out_ready1 = (cyc < 60) ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      check("d1_out_valid", W'(out_valid1), W'(q.size() != 0));
      check("d1_count", W'(count1), W'(q.size()));
      check("d1_in_ready", W'(in_ready1), W'(q.size() == 0 || out_ready1));
      emit = (q.size() != 0) && out_ready1;
      acc  = in_valid1 && (q.size() == 0 || out_ready1);
      if (q.size() != 0) begin
        check("d1_out_round", W'(out_round1), W'(q[0]));
        check("d1_out_data", out_data1, mkdata(q[0]));
      end
      if (emit) begin
        void'(q.pop_front());
        recv++;
      end
      if (acc) begin
        q.push_back(8'(sent));
        sent++;
      end
      step();
    end
    check("d1_no_drops", W'(recv), W'(sent));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/delay_pipe.md
DELAY_PIPE -- requirements
Module: delay_pipe

Interface
REQ-001 Parameter WIDTH, default 512, payload bits per stage (packed c_hash_struct plus c_memory_struct).
REQ-002 Parameter DEPTH, default 4, number of register stages, legal range 1..16; elaboration SHALL fail outside range.
REQ-003 Parameter CW = $clog2(DEPTH+1), derived, width of count.
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 reset_en  in  1  asynchronous, active-low reset.
REQ-006 flush  in  1  synchronous flush; empties the pipe.
REQ-007 in_valid  in  1  upstream has a word.
REQ-008 in_ready  out  1  pipe accepts a word this cycle.
REQ-009 in_round  in  8  round index travelling with the word.
REQ-010 in_data  in  WIDTH  payload.
REQ-011 out_valid  out  1  output stage holds a word.
REQ-012 out_ready  in  1  downstream takes the word this cycle.
REQ-013 out_round  out  8  round index of output word.
REQ-014 out_data  out  WIDTH  payload of output word.
REQ-015 count  out  CW  number of occupied stages, 0..DEPTH.

Function
REQ-016 Stages s0..s(DEPTH-1), each holding valid bit v[k], round and data; s(DEPTH-1) drives out_valid/out_round/out_data directly from registers.
REQ-017 Advance: adv[DEPTH-1] = out_ready; adv[k] = !v[k+1] | adv[k+1] for k<DEPTH-1 (bubble-collapsing elastic pipe).
REQ-018 in_ready = !flush & (!v[0] | adv[0]), combinational.
REQ-019 Input handshake = in_valid & in_ready; s0 loads in_round/in_data and sets v[0]=1 on handshake; if adv[0] and no handshake, v[0] clears.
REQ-020 s(k+1) loads s(k) round/data/valid when adv[k]=1 and v[k]=1; if adv[k+1]=1 and s(k) not moving in, v[k+1] clears.
REQ-021 A stage whose adv is 0 SHALL hold round, data and valid unchanged (no corruption under stall).
REQ-022 Latency: word handshaken in cycle t with no stalls SHALL present out_valid=1 in cycle t+DEPTH; DEPTH=1 equals a single one-cycle delay register.
REQ-023 Throughput: with out_ready held 1, one word per cycle sustained; in_ready stays 1.
REQ-024 Full: all v=1 and out_ready=0 -> in_ready=0; simultaneous out_ready=1 and in_valid=1 on a full pipe SHALL accept and emit in the same cycle, count unchanged.
REQ-025 Order preserved; no word duplicated or dropped except by flush.
REQ-026 count = sum of v[k], registered, updated same edge as v; increments on accept-only, decrements on emit-only, unchanged on both or neither.
REQ-027 flush=1: all v cleared at next edge, count=0, in_ready=0 that cycle, any in_valid that cycle discarded; data/round registers may hold stale values.
REQ-028 flush takes priority over accept and emit in the same cycle; out_valid seen in the flush cycle is still a valid emit if out_ready=1.

Reset
REQ-029 reset_en=0 SHALL immediately (asynchronously) clear all v, all round to 0, all data to 0, count to 0; out_valid=0, out_round=0, out_data=0.
REQ-030 Release of reset_en synchronous to clk is the integrator's responsibility; first accept possible in first cycle after release.
REQ-031 Reset mid-operation discards all in-flight words; no output after release until new input.

Verification
REQ-032 DEPTH=4, out_ready=1, in words round 0..9 back-to-back -> out_valid first in cycle t0+4, rounds 0..9 in order, one per cycle, count steady at 4.
REQ-033 DEPTH=4, load 4 words, out_ready=0 for 6 cycles -> in_ready=0, count=4, out_round frozen at first round; then out_ready=1 with in_valid=1 -> emit and accept same cycle, count stays 4.
REQ-034 Bubble collapse: DEPTH=4, single word then out_ready=0 -> word reaches s3 after 4 cycles; next 3 words fill s0..s2, count=4.
REQ-035 Flush with 3 words in flight plus in_valid=1 -> next cycle count=0, out_valid=0, flushed and concurrent input never appear at output.
REQ-036 Assert reset_en=0 between clock edges with pipe full -> outputs zero before next posedge; after release count=0 until new input.
REQ-037 DEPTH=1, WIDTH=512 random stall pattern -> output equals input stream delayed, scoreboard match, zero drops.
